acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
// - Sequences one acquisition run: paces 12-bit ADC reads, optionally waits for a level trigger,
//   buffers N samples, then drains them one at a time to the Arduino writer.
// - Sits between the top-level collector and the ADC-read / Arduino-write engines.
// - Drives both engines through req/done handshakes, so neither engine is ever active unless the sequencer allows it.
// PARAMETERS
// - DEPTH       100     sample buffer depth (max samples per run)
// - CNT_W       7       width of sample counters; 2**CNT_W > DEPTH
// - SAMPLE_DIV  5000    clk cycles between sample ticks (10 kS/s at 50 MHz)
// - TIMEOUT     65535   max clk cycles a req may stay unanswered before error
// PORTS
// - clk          in   1      50 MHz system clock
// - rst          in   1      asynchronous reset, active-low
// - start        in   1      1-cycle pulse: begin run (ignored unless IDLE)
// - abort        in   1      level: cancel run, return to IDLE
// - num_samples  in   CNT_W  samples per run; latched on start
// - trig_en      in   1      1 = wait for adc_data >= trig_level before storing; latched on start
// - trig_level   in   12     trigger threshold, unsigned; latched on start
// - adc_req      out  1      request one ADC conversion; held until adc_done
// - adc_done     in   1      1-cycle pulse: adc_data valid
// - adc_data     in   12     conversion result
// - tx_req       out  1      request transmission of tx_data; held until tx_done
// - tx_data      out  12     sample being sent; stable while tx_req=1
// - tx_done      in   1      1-cycle pulse: Arduino write finished
// - busy         out  1      1 in any state except IDLE
// - done         out  1      1-cycle pulse on normal run completion
// - overrun      out  1      sticky: sample tick arrived while adc_req outstanding
// - error        out  1      sticky: handshake timeout
// BEHAVIOUR
// - Reset:
//   - all outputs 0
//   - state IDLE; counters, timer and pointers 0
//   - buffer contents are don't-care
// - States: IDLE -> ARM -> CAPTURE -> DRAIN -> IDLE.
// - IDLE:
//   - On start, latch config and clear overrun/error.
//   - Effective count = min(num_samples, DEPTH).
//   - If the count is 0: pulse done on the next cycle and stay IDLE; no req is issued.
//   - Otherwise go to ARM if trig_en, else CAPTURE.
// - Sample timer:
//   - Runs in ARM and CAPTURE.
//   - Ticks every SAMPLE_DIV cycles; the first tick is SAMPLE_DIV cycles after state entry.
//   - At a tick with adc_req=0: raise adc_req on the next cycle.
//   - At a tick with adc_req=1: set overrun; the tick is dropped.
// - adc_req falls the cycle after adc_done.
// - adc_done with adc_req=0 is ignored.
// - ARM:
//   - On adc_done with adc_data >= trig_level: write the sample to buf[0], wr_cnt=1, go to CAPTURE.
//   - Otherwise discard the sample.
// - CAPTURE:
//   - On adc_done: buf[wr_cnt] <= adc_data, wr_cnt++.
//   - When wr_cnt reaches the count: go to DRAIN on the next cycle; the timer stops.
// - DRAIN:
//   - tx_data = buf[rd_ptr], registered one cycle before tx_req rises; tx_req=1.
//   - On tx_done: tx_req=0 for at least 1 cycle, rd_ptr++.
//   - When rd_ptr reaches the count: pulse done, go to IDLE.
// - Timeout: a counter runs while adc_req or tx_req is high.
//   - It reaches TIMEOUT without done: set error, drop reqs, go IDLE, no done pulse.
// - abort, highest priority over every other event in the same cycle:
//   - next cycle: state IDLE, reqs 0, counters cleared, flags retained.
// - A done pulse arriving in the same cycle as abort is ignored.
// - start while busy is ignored.
// - Buffer is written only in ARM/CAPTURE and read only in DRAIN; there are no simultaneous accesses.
// - Count compare is unsigned CNT_W-bit; pointers never wrap (bounded by DEPTH).
// STRUCTURE
// - Package acq_pkg: state encoding (IDLE/ARM/CAPTURE/DRAIN), SAMPLE_W=12, shared width constants.
// - Sub-module acq_buffer: DEPTH x 12 register array, 1 write port, 1 registered read port.
// - Sequencer FSM, sample timer and timeout counter live in acq_sequencer.
// TESTING
// - SAMPLE_DIV=10, num=4, trig_en=0, ADC model answers in 3 cycles with 0x101..0x104
//   -> 4 adc_req spaced 10 cycles; tx_data 0x101,0x102,0x103,0x104 in order; single done pulse.
// - trig_en=1, trig_level=0x800, ADC returns 0x100, 0x7FF, 0x800, 0x900
//   -> first two discarded, buffer holds 0x800 then 0x900; num=2 run completes.
// - num=0 -> done pulse 1 cycle after start, no adc_req/tx_req; num=120 -> exactly 100 samples sent.
// - ADC model delays adc_done 25 cycles with SAMPLE_DIV=10 -> overrun=1, run still completes.
// - TIMEOUT=50, tx_done never asserted -> error=1 after 50 cycles of tx_req, busy=0, no done.
// - abort mid-CAPTURE with adc_done in the same cycle -> IDLE next cycle, sample not stored;
//   async rst mid-DRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer and its sample buffer.
package acq_pkg;

  localparam int unsigned SAMPLE_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture,
    StDrain
  } acq_state_e;

endpackage

// File: rtl/acq_buffer.sv
// Sample store: DEPTH x SAMPLE_W register array, one write port, one registered read port.
module acq_buffer
  import acq_pkg::*;
#(
  parameter int unsigned DEPTH  = 100,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: paced ADC requests, optional level trigger, buffering, and
// one-at-a-time drain to the Arduino writer, with overrun/timeout flags and abort.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int unsigned DEPTH      = 100,
  parameter int unsigned CNT_W      = 7,
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_samples,
  input  logic                trig_en,
  input  logic [SAMPLE_W-1:0] trig_level,
  output logic                adc_req,
  input  logic                adc_done,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                tx_req,
  output logic [SAMPLE_W-1:0] tx_data,
  input  logic                tx_done,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                error
);

  localparam int unsigned TMR_W = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMR_W-1:0] TICK_AT = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_AT   = TO_W'(TIMEOUT - 1);

  acq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 trig_en_q, trig_en_d;
  logic [SAMPLE_W-1:0]  trig_level_q, trig_level_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic                 adc_req_q, adc_req_d;
  logic                 tx_req_q, tx_req_d;
  logic                 load_q, load_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic                 error_q, error_d;

  logic                 wr_en, rd_en, tick, adc_ack, tx_ack, req_open, timed_out;
  logic [CNT_W-1:0]     wr_addr;
  logic [CNT_W-1:0]     eff_cnt;

  assign eff_cnt   = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
  assign adc_ack   = adc_req_q & adc_done;
  assign tx_ack    = tx_req_q & tx_done;
  assign req_open  = (adc_req_q | tx_req_q) & ~adc_ack & ~tx_ack;
  assign timed_out = req_open && (to_q == TO_AT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    trig_en_d    = trig_en_q;
    trig_level_d = trig_level_q;
    wr_cnt_d     = wr_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    tmr_d        = '0;
    to_d         = '0;
    adc_req_d    = adc_req_q;
    tx_req_d     = tx_req_q;
    load_d       = load_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    error_d      = error_q;
    wr_en        = 1'b0;
    wr_addr      = wr_cnt_q;
    rd_en        = 1'b0;
    tick         = 1'b0;

    if (state_q == StArm || state_q == StCapture) begin
      if (tmr_q == TICK_AT) tick = 1'b1;
      else                  tmr_d = tmr_q + TMR_W'(1);
    end

    if (tick) begin
      if (adc_req_q) overrun_d = 1'b1;
      else           adc_req_d = 1'b1;
    end
    if (adc_ack) adc_req_d = 1'b0;
    if (req_open) to_d = to_q + TO_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d        = eff_cnt;
          trig_en_d    = trig_en;
          trig_level_d = trig_level;
          overrun_d    = 1'b0;
          error_d      = 1'b0;
          wr_cnt_d     = '0;
          rd_ptr_d     = '0;
          if (eff_cnt == '0) done_d  = 1'b1;
          else               state_d = trig_en ? StArm : StCapture;
        end
      end
      StArm: begin
        if (adc_ack && adc_data >= trig_level_q) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_cnt_d = CNT_ONE;
          tmr_d    = '0;
          state_d  = (cnt_q == CNT_ONE) ? StDrain : StCapture;
        end
      end
      StCapture: begin
        if (adc_ack) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (wr_cnt_q + CNT_ONE == cnt_q) state_d = StDrain;
        end
      end
      StDrain: begin
        // Read is issued one cycle ahead so tx_data is settled before tx_req rises.
        if (tx_ack) begin
          tx_req_d = 1'b0;
          rd_ptr_d = rd_ptr_q + CNT_ONE;
          if (rd_ptr_q + CNT_ONE == cnt_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else if (load_q) begin
          tx_req_d = 1'b1;
          load_d   = 1'b0;
        end else if (!tx_req_q) begin
          rd_en  = 1'b1;
          load_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timed_out) begin
      error_d   = 1'b1;
      adc_req_d = 1'b0;
      tx_req_d  = 1'b0;
      load_d    = 1'b0;
      to_d      = '0;
      state_d   = StIdle;
    end

    // Abort overrides everything, including a handshake completing this cycle.
    if (abort) begin
      state_d   = StIdle;
      adc_req_d = 1'b0;
      tx_req_d  = 1'b0;
      load_d    = 1'b0;
      wr_cnt_d  = '0;
      rd_ptr_d  = '0;
      tmr_d     = '0;
      to_d      = '0;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      error_d   = error_q;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      trig_en_q    <= 1'b0;
      trig_level_q <= '0;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      tmr_q        <= '0;
      to_q         <= '0;
      adc_req_q    <= 1'b0;
      tx_req_q     <= 1'b0;
      load_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trig_en_q    <= trig_en_d;
      trig_level_q <= trig_level_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      tmr_q        <= tmr_d;
      to_q         <= to_d;
      adc_req_q    <= adc_req_d;
      tx_req_q     <= tx_req_d;
      load_q       <= load_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      error_q      <= error_d;
    end
  end

  acq_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (CNT_W)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (adc_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (tx_data)
  );

  assign adc_req = adc_req_q;
  assign tx_req  = tx_req_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign overrun = overrun_q;
  assign error   = error_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: ADC/Arduino responders feed a run-level reference model,
// and a negedge monitor pops expected samples whenever tx_req rises.
module tb_acq_sequencer;
  import acq_pkg::*;

  localparam int unsigned DEPTH      = 100;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned SAMPLE_DIV = 10;
  localparam int unsigned TIMEOUT    = 50;

  logic                clk, rst, start, abort, trig_en;
  logic [CNT_W-1:0]    num_samples;
  logic [SAMPLE_W-1:0] trig_level, adc_data, tx_data;
  logic                adc_req, adc_done, tx_req, tx_done;
  logic                busy, done, overrun, error;

  acq_sequencer #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .SAMPLE_DIV (SAMPLE_DIV),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_samples (num_samples),
    .trig_en     (trig_en),
    .trig_level  (trig_level),
    .adc_req     (adc_req),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .error       (error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: per-run rules, not cycle behaviour.
  logic [SAMPLE_W-1:0] exp_q[$];
  logic [SAMPLE_W-1:0] adc_src[$];
  int  run_cnt, stored;
  bit  run_active, armed, m_trig;
  logic [SAMPLE_W-1:0] m_level;

  // Responder configuration and monitor observations.
  int  adc_delay = 3, tx_delay = 2, abort_at = 0, adc_idx = 0;
  bit  tx_hang = 0;
  int  done_seen, adc_rises, tx_sent, tx_high, start_cyc, abort_cyc, busy_fall_cyc, done_cyc;
  bit  busy_seen;
  int  rise_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_sample(input logic [SAMPLE_W-1:0] v);
    if (!run_active) return;
    if (m_trig && !armed && v < m_level) return;
    armed = 1;
    if (stored < run_cnt) begin
      exp_q.push_back(v);
      stored++;
    end
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC engine model: answers each request after adc_delay cycles.
  initial begin
    logic [SAMPLE_W-1:0] v;
    adc_done = 0;
    adc_data = '0;
    abort    = 0;
    forever begin
      @(posedge clk); #1;
      if (adc_req) begin
        for (int i = 1; i < adc_delay; i++) begin @(posedge clk); #1; end
        v = (adc_src.size() > 0) ? adc_src.pop_front() : SAMPLE_W'($urandom);
        adc_idx++;
        adc_data = v;
        adc_done = 1;
        if (abort_at == adc_idx) begin
          abort = 1;
          run_active = 0;
          exp_q.delete();
        end else begin
          model_sample(v);
        end
        @(posedge clk); #1;
        adc_done = 0;
        abort    = 0;
      end
    end
  end

  // Arduino writer model.
  initial begin
    tx_done = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_req && !tx_hang) begin
        for (int i = 1; i < tx_delay; i++) begin @(posedge clk); #1; end
        tx_done = 1;
        @(posedge clk); #1;
        tx_done = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_req rise.
  initial begin
    logic tx_prev, adc_prev, busy_prev;
    logic [SAMPLE_W-1:0] txd_prev, e;
    tx_prev = 0; adc_prev = 0; busy_prev = 0; txd_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (start) start_cyc = cyc;
        if (abort) abort_cyc = cyc;
        if (busy) busy_seen = 1;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        if (done) begin done_seen++; done_cyc = cyc; end
        if (tx_req) tx_high++;
        if (adc_req && !adc_prev) begin adc_rises++; rise_q.push_back(cyc); end
        if (tx_req && !tx_prev) begin
          tx_sent++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected actual=%0h required=no transfer", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e));
          end
        end else if (tx_req && tx_prev && tx_data !== txd_prev) begin
          checks++; errors++;
          $display("FAIL tx_stable actual=%0h required=%0h", tx_data, txd_prev);
        end
      end
      tx_prev = tx_req; adc_prev = adc_req; busy_prev = busy; txd_prev = tx_data;
    end
  end

  task automatic run_start(input int num, input bit ten, input logic [SAMPLE_W-1:0] lvl);
    run_cnt = (num > int'(DEPTH)) ? int'(DEPTH) : num;
    stored = 0; armed = 0; m_trig = ten; m_level = lvl; exp_q.delete(); run_active = 1;
    done_seen = 0; adc_rises = 0; tx_sent = 0; tx_high = 0; busy_seen = 0; adc_idx = 0;
    rise_q.delete(); done_cyc = -1; busy_fall_cyc = -1; abort_cyc = -1;
    @(posedge clk); #1;
    num_samples = CNT_W'(num); trig_en = ten; trig_level = lvl; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    check(name, 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    run_active = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 0; start = 0; num_samples = '0; trig_en = 0; trig_level = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({adc_req, tx_req, tx_data, busy, done, overrun, error}), 32'd0);
    rst = 1;

    // Plain 4-sample run with fixed data and pacing checks.
    adc_delay = 3; tx_delay = 2;
    adc_src = '{12'h101, 12'h102, 12'h103, 12'h104};
    run_start(4, 0, '0);
    wait_idle("t1_finish", 400);
    check("t1_drained", exp_q.size(), 0);
    check("t1_tx_count", tx_sent, 4);
    check("t1_done", done_seen, 1);
    check("t1_adc_reqs", adc_rises, 4);
    if (rise_q.size() > 0) check("t1_first_tick", rise_q[0] - start_cyc, SAMPLE_DIV + 1);
    else check("t1_first_tick", 32'(rise_q.size()), 32'd1);
    for (int i = 1; i < rise_q.size(); i++) check("t1_gap", rise_q[i] - rise_q[i-1], SAMPLE_DIV);
    check("t1_flags", 32'({overrun, error}), 32'd0);

    // Level trigger discards below-threshold samples.
    adc_src = '{12'h100, 12'h7FF, 12'h800, 12'h900};
    run_start(2, 1, 12'h800);
    wait_idle("t2_finish", 400);
    check("t2_drained", exp_q.size(), 0);
    check("t2_tx_count", tx_sent, 2);
    check("t2_done", done_seen, 1);
    check("t2_adc_reqs", adc_rises, 4);

    // Zero-length run.
    run_start(0, 0, '0);
    wait_idle("t3_finish", 10);
    check("t3_done", done_seen, 1);
    check("t3_done_time", done_cyc - start_cyc, 1);
    check("t3_no_reqs", adc_rises + tx_sent, 0);
    check("t3_never_busy", 32'(busy_seen), 32'd0);

    // Oversized request is clamped to DEPTH; random data and handshake latencies.
    adc_delay = $urandom_range(5, 1); tx_delay = $urandom_range(4, 1);
    run_start(120, 0, '0);
    wait_idle("t4_finish", 5000);
    check("t4_tx_count", tx_sent, DEPTH);
    check("t4_drained", exp_q.size(), 0);
    check("t4_done", done_seen, 1);

    // Slow ADC: ticks land while a request is outstanding.
    adc_delay = 25; tx_delay = 2;
    run_start(3, 0, '0);
    wait_idle("t5_finish", 600);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_done", done_seen, 1);
    check("t5_drained", exp_q.size(), 0);
    check("t5_error", 32'(error), 32'd0);

    // Writer never answers: timeout.
    adc_delay = 3; tx_hang = 1;
    run_start(1, 0, '0);
    check("t6_start_clears_overrun", 32'(overrun), 32'd0);
    wait_idle("t6_finish", 300);
    check("t6_error", 32'(error), 32'd1);
    check("t6_req_cycles", tx_high, TIMEOUT);
    check("t6_no_done", done_seen, 0);
    check("t6_busy", 32'(busy), 32'd0);
    tx_hang = 0;

    // Abort coinciding with adc_done mid-capture; flags are retained.
    adc_delay = 25; abort_at = 2;
    run_start(3, 0, '0);
    check("t7_start_clears_error", 32'(error), 32'd0);
    wait_idle("t7_finish", 400);
    abort_at = 0;
    repeat (30) @(posedge clk);
    #1;
    check("t7_idle_next_cycle", busy_fall_cyc - abort_cyc, 1);
    check("t7_adc_reqs", adc_rises, 2);
    check("t7_no_tx_no_done", tx_sent + done_seen, 0);
    check("t7_overrun_kept", 32'(overrun), 32'd1);
    check("t7_reqs_low", 32'({adc_req, tx_req}), 32'd0);

    // Asynchronous reset while draining.
    adc_delay = 3; tx_delay = 8;
    run_start(3, 0, '0);
    begin
      int n = 0;
      while (!tx_req && n < 300) begin @(posedge clk); #1; n++; end
    end
    check("t8_reach_drain", 32'(tx_req), 32'd1);
    @(negedge clk); #2;
    rst = 0;
    run_active = 0;
    exp_q.delete();
    #1;
    check("t8_async_reset", 32'({adc_req, tx_req, tx_data, busy, done, overrun, error}), 32'd0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
